instr_fetch_unit: RTL and testbench

- Front end of the MIPS datapath. Produces the instruction stream whose opcode field feeds the control unit; this block is the producer side of that decode interface.
- Keeps the PC and issues word fetches to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words and presents them to decode over a valid/ready channel.
- Takes branch/jump redirects from the execute stage and discards wrong-path fetches.

---
 rtl/mips_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: instruction width, opcode field position and common opcodes.
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO; a push is visible at the head one cycle later (no bypass).
// Push into a full FIFO is accepted only alongside a pop; flush overrides push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH[AW:0]);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: empty gates every use of the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !do_pop && !flush))
    else $error("fetch_fifo overflow");

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch front end: PC, credit-limited imem requests, redirect squash. Response-to-inst_valid is 1 cycle.
// Requests stop once outstanding + buffered reaches DEPTH; decode backpressure holds the buffer head.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic [5:0]         inst_opcode
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = DEPTH[CW:0];

  logic                      run;
  logic [ADDR_W-1:0]         pc;
  logic [CW-1:0]             drop_cnt;
  logic [CW-1:0]             outstanding;
  logic [CW-1:0]             buf_count;
  logic                      buf_empty;
  logic                      shadow_empty;
  logic [ADDR_W-1:0]         rsp_pc;
  logic [INSTR_W+ADDR_W-1:0] buf_head;
  logic [CW:0]               credit_used;
  logic                      req_fire;
  logic                      rsp_keep;
  logic                      buf_pop;

  assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid = run && (credit_used < CREDITS) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign inst_valid  = !buf_empty && !redirect_valid;
  assign buf_pop     = inst_valid && inst_ready;
  assign inst_data   = buf_empty ? NOP_WORD : buf_head[INSTR_W+ADDR_W-1 -: INSTR_W];
  assign inst_pc     = buf_empty ? '0 : buf_head[ADDR_W-1:0];
  assign inst_opcode = inst_data[OPCODE_MSB:OPCODE_LSB];

  // run holds off the first request until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        pc       <= redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
        drop_cnt <= outstanding - {{(CW-1){1'b0}}, imem_rsp_valid};
      end else begin
        if (req_fire) pc <= pc + {{(ADDR_W-3){1'b0}}, 3'd4};
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // In-flight addresses; its occupancy is the outstanding-fetch count.
  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .count     (outstanding),
    .empty     (shadow_empty),
    .head      (rsp_pc)
  );

  fetch_fifo #(.WIDTH(INSTR_W+ADDR_W), .DEPTH(DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .count     (buf_count),
    .empty     (buf_empty),
    .head      (buf_head)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && shadow_empty))
    else $error("imem response with no fetch in flight");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based model of fetches in flight and buffered words.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [5:0]  inst_opcode;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode)
  );

  typedef struct { logic [31:0] addr; int acc; bit stale; } fetch_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;

  fetch_t      memq[$];
  entry_t      bufq[$];
  logic [31:0] m_pc = RESET_PC;
  bit          started = 0;
  int          cyc = 0;

  int          total = 0;
  int          bad = 0;

  int          rdy_pct = 100, rsp_pct = 100, dec_pct = 100, redir_pm = 0;
  bit          force_redir = 0, force_on_rsp = 0;
  logic [31:0] force_pc = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [5:0] op;
    if (addr == 32'h4) return 32'h8C22_0004;
    case (addr[3:2])
      2'd0: op = OP_RTYPE;
      2'd1: op = OP_LW;
      2'd2: op = OP_SW;
      default: op = OP_BEQ;
    endcase
    return {op, addr[27:2] ^ 26'h2A5_5A5A};
  endfunction

  function automatic logic [31:0] rand_target();
    case ($urandom_range(3))
      0: return $urandom;
      1: return 32'hFFFF_FFF0 | 32'($urandom_range(15));
      default: return 32'($urandom_range(1023));
    endcase
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_inst_data"}, 64'(inst_data), 64'd0);
    chk({tag, "_inst_pc"}, 64'(inst_pc), 64'd0);
    chk({tag, "_opcode"}, 64'(inst_opcode), 64'd0);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bit     exp_req;
      bit     exp_iv;
      bit     do_redir;
      fetch_t f;
      @(negedge clk);
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      inst_ready     = ($urandom_range(99) < dec_pct);
      if (memq.size() > 0 && memq[0].acc < cyc && $urandom_range(99) < rsp_pct) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(memq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      do_redir = 0;
      if (force_redir && (!force_on_rsp || imem_rsp_valid)) begin
        do_redir    = 1;
        redirect_pc = force_pc;
        force_redir = 0;
      end else if ($urandom_range(999) < redir_pm) begin
        do_redir    = 1;
        redirect_pc = rand_target();
      end else begin
        redirect_pc = $urandom;
      end
      redirect_valid = do_redir;
      #1;
      exp_req = started && (memq.size() + bufq.size() < DEPTH) && !redirect_valid;
      exp_iv  = (bufq.size() > 0) && !redirect_valid;
      chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
      if (exp_req) chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
      chk("inst_valid", 64'(inst_valid), 64'(exp_iv));
      if (exp_iv) begin
        chk("inst_pc", 64'(inst_pc), 64'(bufq[0].pc));
        chk("inst_data", 64'(inst_data), 64'(bufq[0].data));
        chk("inst_opcode", 64'(inst_opcode), 64'(bufq[0].data >> 26));
      end
      @(posedge clk);
      if (exp_iv && inst_ready) void'(bufq.pop_front());
      if (imem_rsp_valid) begin
        f = memq.pop_front();
        if (!f.stale && !redirect_valid) bufq.push_back('{f.addr, mem_word(f.addr)});
      end
      if (redirect_valid) begin
        bufq.delete();
        foreach (memq[k]) memq[k].stale = 1;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (exp_req && imem_req_ready) begin
        memq.push_back('{m_pc, cyc, 0});
        m_pc = m_pc + 32'd4;
      end
      started = 1;
      cyc++;
    end
  endtask

  task automatic set_knobs(input int rdy, input int rsp, input int dec, input int redir);
    rdy_pct = rdy; rsp_pct = rsp; dec_pct = dec; redir_pm = redir;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 check_cleared("reset");
    release_reset();

    // Streaming from reset.
    set_knobs(100, 100, 100, 0);
    run_cycles(30);

    // Decode stall, then single ready pulses.
    set_knobs(100, 100, 0, 0);
    run_cycles(12);
    set_knobs(100, 100, 100, 0);
    run_cycles(1);
    set_knobs(100, 100, 0, 0);
    run_cycles(8);
    set_knobs(100, 100, 100, 0);
    run_cycles(10);

    // Memory not ready for a stretch.
    set_knobs(0, 100, 100, 0);
    run_cycles(5);
    set_knobs(100, 100, 100, 0);
    run_cycles(10);

    // Redirect with slow responses in flight.
    set_knobs(100, 30, 100, 0);
    run_cycles(6);
    force_pc = 32'h40; force_on_rsp = 0; force_redir = 1;
    run_cycles(30);

    // Redirect to an unaligned target coinciding with a response.
    set_knobs(100, 100, 100, 0);
    run_cycles(5);
    force_pc = 32'h43; force_on_rsp = 1; force_redir = 1;
    run_cycles(20);

    // PC wrap at the top of the address space.
    force_pc = 32'hFFFF_FFF8; force_on_rsp = 0; force_redir = 1;
    run_cycles(12);

    // Random mix.
    for (int p = 0; p < 6; p++) begin
      set_knobs($urandom_range(40, 100), $urandom_range(20, 100), $urandom_range(10, 100), 40);
      run_cycles(300);
    end

    // Reset in the middle of traffic.
    set_knobs(100, 60, 50, 0);
    run_cycles(10);
    @(negedge clk);
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1 check_cleared("midreset");
    memq.delete();
    bufq.delete();
    m_pc = RESET_PC;
    started = 0;
    release_reset();
    set_knobs(100, 100, 100, 0);
    run_cycles(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
